// File: rtl/act_bank_ctrl.sv
// Ping-pong bank sequencer for the activation SRAM: fills the free bank from DMA, plays a full bank out as L reads + DRAIN_CYCLES idle + done pulse.
// Start-to-first-read latency 1 cycle; DMA is stalled while the target bank is full. Perf counters exist only with ACT_BANK_CTRL_PERF_EN.
module act_bank_ctrl #(
    parameter int ADDR_WIDTH   = 7,
    parameter int DRAIN_CYCLES = 13
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  dma_valid,
    input  logic                  dma_last,
    output logic                  dma_ready,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic                  bank_sel_wr,
    input  logic                  tile_start,
    input  logic                  tile_keep,
    output logic                  tile_ready,
    output logic                  tile_busy,
    output logic                  tile_done,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] k_idx,
    output logic                  bank_sel_rd,
    output logic [1:0]            bank_full,
    output logic                  ovf_err,
    output logic [31:0]           perf_read_cycles,
    output logic [31:0]           perf_starve_cycles
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    localparam int DC_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DC_W-1:0]       DC_LAST = DC_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
    localparam logic [DC_W-1:0]       DC_ONE  = DC_W'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_MAX = '1;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   LEN_ONE = (ADDR_WIDTH+1)'(1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic                  wr_bank_q, wr_bank_d;
    logic [1:0]            bank_full_q, bank_full_d;
    logic [ADDR_WIDTH:0]   len_q [2];
    logic [ADDR_WIDTH:0]   len_d [2];
    logic                  ovf_q, ovf_d;
    logic                  rd_bank_q, rd_bank_d;
    logic                  keep_q, keep_d;
    logic [ADDR_WIDTH-1:0] k_idx_q, k_idx_d;
    logic                  rd_en_q, rd_en_d;
    logic                  bank_sel_rd_q, bank_sel_rd_d;
    logic                  tile_done_q, tile_done_d;
    logic [DC_W-1:0]       drain_cnt_q, drain_cnt_d;

    assign dma_ready   = !bank_full_q[wr_bank_q];
    assign we          = dma_valid && dma_ready;
    assign waddr       = wr_ptr_q;
    assign bank_sel_wr = wr_bank_q;
    assign tile_ready  = (state_q == S_IDLE) && bank_full_q[rd_bank_q];
    assign tile_busy   = (state_q != S_IDLE);
    assign tile_done   = tile_done_q;
    assign rd_en       = rd_en_q;
    assign k_idx       = k_idx_q;
    assign bank_sel_rd = bank_sel_rd_q;
    assign bank_full   = bank_full_q;
    assign ovf_err     = ovf_q;

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        wr_bank_d     = wr_bank_q;
        bank_full_d   = bank_full_q;
        len_d[0]      = len_q[0];
        len_d[1]      = len_q[1];
        ovf_d         = ovf_q;
        rd_bank_d     = rd_bank_q;
        keep_d        = keep_q;
        k_idx_d       = k_idx_q;
        rd_en_d       = 1'b0;
        bank_sel_rd_d = bank_sel_rd_q;
        tile_done_d   = 1'b0;
        drain_cnt_d   = drain_cnt_q;

        // A bank closes on dma_last or when it runs out of rows; running out is an overflow.
        if (we) begin
            if (dma_last || wr_ptr_q == PTR_MAX) begin
                bank_full_d[wr_bank_q] = 1'b1;
                len_d[wr_bank_q]       = {1'b0, wr_ptr_q} + LEN_ONE;
                wr_ptr_d               = '0;
                wr_bank_d              = !wr_bank_q;
                if (!dma_last) begin
                    ovf_d = 1'b1;
                end
            end else begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (tile_start && tile_ready) begin
                    state_d       = S_READ;
                    rd_en_d       = 1'b1;
                    k_idx_d       = '0;
                    keep_d        = tile_keep;
                    bank_sel_rd_d = rd_bank_q;
                end
            end
            S_READ: begin
                if ({1'b0, k_idx_q} == (len_q[rd_bank_q] - LEN_ONE)) begin
                    if (DRAIN_CYCLES == 0) begin
                        state_d     = S_DONE;
                        tile_done_d = 1'b1;
                    end else begin
                        state_d     = S_DRAIN;
                        drain_cnt_d = '0;
                    end
                end else begin
                    rd_en_d = 1'b1;
                    k_idx_d = k_idx_q + PTR_ONE;
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == DC_LAST) begin
                    state_d     = S_DONE;
                    tile_done_d = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + DC_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (!keep_q) begin
                    bank_full_d[rd_bank_q] = 1'b0;
                    rd_bank_d              = !rd_bank_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) begin
            state_d       = S_IDLE;
            wr_ptr_d      = '0;
            wr_bank_d     = 1'b0;
            bank_full_d   = 2'b00;
            ovf_d         = 1'b0;
            rd_bank_d     = 1'b0;
            keep_d        = 1'b0;
            rd_en_d       = 1'b0;
            bank_sel_rd_d = 1'b0;
            tile_done_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            wr_bank_q     <= 1'b0;
            bank_full_q   <= 2'b00;
            len_q[0]      <= '0;
            len_q[1]      <= '0;
            ovf_q         <= 1'b0;
            rd_bank_q     <= 1'b0;
            keep_q        <= 1'b0;
            k_idx_q       <= '0;
            rd_en_q       <= 1'b0;
            bank_sel_rd_q <= 1'b0;
            tile_done_q   <= 1'b0;
            drain_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            wr_bank_q     <= wr_bank_d;
            bank_full_q   <= bank_full_d;
            len_q[0]      <= len_d[0];
            len_q[1]      <= len_d[1];
            ovf_q         <= ovf_d;
            rd_bank_q     <= rd_bank_d;
            keep_q        <= keep_d;
            k_idx_q       <= k_idx_d;
            rd_en_q       <= rd_en_d;
            bank_sel_rd_q <= bank_sel_rd_d;
            tile_done_q   <= tile_done_d;
            drain_cnt_q   <= drain_cnt_d;
        end
    end

`ifdef ACT_BANK_CTRL_PERF_EN
    logic [31:0] perf_rd_q, perf_st_q;
    logic        starve;

    // Starvation: compute asked for a tile while the next bank to read is still empty.
    assign starve = (state_q == S_IDLE) && tile_start && !bank_full_q[rd_bank_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_rd_q <= '0;
            perf_st_q <= '0;
        end else if (flush) begin
            perf_rd_q <= '0;
            perf_st_q <= '0;
        end else begin
            if (rd_en_q && perf_rd_q != '1) begin
                perf_rd_q <= perf_rd_q + 32'd1;
            end
            if (starve && perf_st_q != '1) begin
                perf_st_q <= perf_st_q + 32'd1;
            end
        end
    end

    assign perf_read_cycles   = perf_rd_q;
    assign perf_starve_cycles = perf_st_q;
`else
    assign perf_read_cycles   = 32'd0;
    assign perf_starve_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_act_bank_ctrl.sv
// Scoreboard bench for act_bank_ctrl: a bank-level reference model queues expected writes, reads, done pulses and status per cycle.
module tb_act_bank_ctrl;

    localparam int AW    = 7;
    localparam int D     = 13;
    localparam int DEPTH = 1 << AW;

    logic          clk, rst, flush, dma_valid, dma_last, tile_start, tile_keep;
    logic          dma_ready, we, bank_sel_wr, tile_ready, tile_busy, tile_done, rd_en, bank_sel_rd, ovf_err;
    logic [AW-1:0] waddr, k_idx;
    logic [1:0]    bank_full;
    logic [31:0]   perf_read_cycles, perf_starve_cycles;

    act_bank_ctrl #(.ADDR_WIDTH(AW), .DRAIN_CYCLES(D)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .dma_valid(dma_valid), .dma_last(dma_last), .dma_ready(dma_ready),
        .we(we), .waddr(waddr), .bank_sel_wr(bank_sel_wr),
        .tile_start(tile_start), .tile_keep(tile_keep), .tile_ready(tile_ready),
        .tile_busy(tile_busy), .tile_done(tile_done),
        .rd_en(rd_en), .k_idx(k_idx), .bank_sel_rd(bank_sel_rd),
        .bank_full(bank_full), .ovf_err(ovf_err),
        .perf_read_cycles(perf_read_cycles), .perf_starve_cycles(perf_starve_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct { int bank; int idx; int cyc; } ev_t;
    typedef struct { logic [5:0] ctl; longint pr; longint ps; } st_t;

    ev_t wq[$];
    ev_t rq[$];
    ev_t dq[$];
    st_t stq[$];

    int  errors = 0;
    int  checks = 0;
    int  cyc    = 0;
    bit  mon_en = 1'b0;

    // Reference model: bank-level bookkeeping with cycle timestamps
    bit [1:0] m_full;
    int       m_len[2];
    int       m_wb, m_wp, m_rb;
    bit       m_ovf;
    int       m_idle_at, m_rel_cyc, m_rd_from, m_rd_to;
    bit       m_rel_pend;
    longint   m_pr, m_ps;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_eval(input bit v, input bit l, input bit s, input bit kp, input bit f);
        int  c;
        int  blen;
        bit  idle, rdy, rd_now, starve;
        st_t st;
        c = cyc;
        if (m_rel_pend && c > m_rel_cyc) begin
            m_full[m_rb] = 1'b0;
            m_rb         = m_rb ^ 1;
            m_rel_pend   = 1'b0;
        end
        idle   = (c >= m_idle_at);
        rdy    = !m_full[m_wb];
        st.ctl = {rdy, m_full[1], m_full[0], m_ovf, idle && m_full[m_rb], !idle};
`ifdef ACT_BANK_CTRL_PERF_EN
        st.pr = m_pr;
        st.ps = m_ps;
`else
        st.pr = 0;
        st.ps = 0;
`endif
        stq.push_back(st);
        rd_now = (c >= m_rd_from) && (c <= m_rd_to);
        starve = idle && s && !m_full[m_rb];

        if (idle && s && m_full[m_rb] && !f) begin
            blen = m_len[m_rb];
            for (int k = 0; k < blen; k++) rq.push_back('{m_rb, k, c + 1 + k});
            dq.push_back('{m_rb, 0, c + blen + D + 1});
            m_idle_at = c + blen + D + 2;
            m_rd_from = c + 1;
            m_rd_to   = c + blen;
            if (!kp) begin
                m_rel_pend = 1'b1;
                m_rel_cyc  = c + blen + D + 1;
            end
        end

        if (v && rdy) begin
            wq.push_back('{m_wb, m_wp, c});
            if (!f) begin
                if (l || m_wp == DEPTH - 1) begin
                    m_full[m_wb] = 1'b1;
                    m_len[m_wb]  = m_wp + 1;
                    if (!l) m_ovf = 1'b1;
                    m_wp = 0;
                    m_wb = m_wb ^ 1;
                end else begin
                    m_wp++;
                end
            end
        end

        if (f) begin
            while (rq.size() > 0 && rq[rq.size()-1].cyc > c) void'(rq.pop_back());
            while (dq.size() > 0 && dq[dq.size()-1].cyc > c) void'(dq.pop_back());
            m_full = 2'b00; m_wp = 0; m_wb = 0; m_rb = 0; m_ovf = 1'b0; m_rel_pend = 1'b0;
            if (m_idle_at > c + 1) m_idle_at = c + 1;
            if (m_rd_to > c) m_rd_to = c;
            m_pr = 0;
            m_ps = 0;
        end else begin
            if (rd_now) m_pr++;
            if (starve) m_ps++;
        end
    endtask

    task automatic cycle(input bit v, input bit l, input bit s, input bit kp, input bit f);
        dma_valid = v; dma_last = l; tile_start = s; tile_keep = kp; flush = f;
        model_eval(v, l, s, kp, f);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic fill(input int n, input bit with_last);
        for (int i = 0; i < n; i++) cycle(1'b1, with_last && (i == n - 1), 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: pops expectations whenever the DUT presents an event
    ev_t e;
    st_t st_m;
    always @(negedge clk) begin
        if (mon_en) begin
            if (stq.size() == 0) begin
                chk("status_expectation", tile_busy, 1'bx);
            end else begin
                st_m = stq.pop_front();
                chk("status", {dma_ready, bank_full, ovf_err, tile_ready, tile_busy}, st_m.ctl);
                chk("perf_read", perf_read_cycles, st_m.pr);
                chk("perf_starve", perf_starve_cycles, st_m.ps);
            end
            if (we) begin
                if (wq.size() == 0) chk("we_extra", we, 1'b0);
                else begin
                    e = wq.pop_front();
                    chk("wr_bank", bank_sel_wr, e.bank);
                    chk("waddr", waddr, e.idx);
                    chk("wr_cycle", cyc, e.cyc);
                end
            end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
                chk("we_missing", we, 1'b1);
                void'(wq.pop_front());
            end
            if (rd_en) begin
                if (rq.size() == 0) chk("rd_en_extra", rd_en, 1'b0);
                else begin
                    e = rq.pop_front();
                    chk("rd_bank", bank_sel_rd, e.bank);
                    chk("k_idx", k_idx, e.idx);
                    chk("rd_cycle", cyc, e.cyc);
                end
            end else if (rq.size() > 0 && rq[0].cyc <= cyc) begin
                chk("rd_en_missing", rd_en, 1'b1);
                void'(rq.pop_front());
            end
            if (tile_done) begin
                if (dq.size() == 0) chk("done_extra", tile_done, 1'b0);
                else begin
                    e = dq.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                end
            end else if (dq.size() > 0 && dq[0].cyc <= cyc) begin
                chk("done_missing", tile_done, 1'b1);
                void'(dq.pop_front());
            end
        end
    end

    initial begin
        m_full = 2'b00; m_len[0] = 0; m_len[1] = 0; m_wb = 0; m_wp = 0; m_rb = 0; m_ovf = 1'b0;
        m_idle_at = 0; m_rel_cyc = 0; m_rel_pend = 1'b0; m_rd_from = 0; m_rd_to = -1; m_pr = 0; m_ps = 0;
        rst = 1'b1; flush = 1'b0; dma_valid = 1'b1; dma_last = 1'b0; tile_start = 1'b0; tile_keep = 1'b0;
        #12;
        chk("reset_dma_ready", dma_ready, 1'b1);
        chk("reset_we", we, 1'b1);
        chk("reset_waddr", waddr, 0);
        chk("reset_bank_sel_wr", bank_sel_wr, 1'b0);
        chk("reset_read_side", {tile_ready, tile_busy, tile_done, rd_en, k_idx, bank_sel_rd}, 0);
        chk("reset_flags", {bank_full, ovf_err}, 0);
        chk("reset_perf", {perf_read_cycles, perf_starve_cycles}, 0);
        dma_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc    = 0;
        mon_en = 1'b1;

        // Single 5-beat tile, full playback with drain
        fill(5, 1'b1);
        idle(2);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(25);

        // Both banks filled (3 and 4 beats) with valid held, then back-to-back starts
        for (int i = 0; i < 9; i++) cycle(1'b1, (i == 2) || (i == 6), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 50; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Overflow: 128 beats without last, 129th lands in bank 1, then full-depth playback
        fill(129, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(150);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Keep replay, then release, then a start with nothing ready
        fill(3, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(20);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(20);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(3);

        // Flush in the middle of READ
        fill(5, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(5);

        // Random traffic
        for (int i = 0; i < 4000; i++)
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 3,
                  $urandom_range(0, 9) < 3, $urandom_range(0, 299) == 0);
        idle(40);

        mon_en = 1'b0;
        chk("writes_outstanding", wq.size(), 0);
        chk("reads_outstanding", rq.size(), 0);
        chk("dones_outstanding", dq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
